piso_serial_tx: RTL and testbench

- Parallel-in, serial-out transmitter. Produces the registered bit stream that a downstream posedge D flip-flop, or a chain of them, samples one bit per clock.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk cycle, with a qualifying valid strobe.
- Sits between a parallel producer and any posedge-sampling serial receiver or deserializer in the design.

---
 rtl/piso_serial_tx.sv | 134 +++++++++++++
 tb/tb_piso_serial_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: MSB-first, valid/ready input, done pulse.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serial_tx #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic last_bit;
    logic accept;

    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

`ifdef PISO_PARITY_EN
    assign done = (state_q == PAR);
`else
    assign done = last_bit;
`endif

    assign din_ready  = (state_q == IDLE) || done;
    assign accept     = din_valid && din_ready;
    assign busy       = (state_q != IDLE);
    assign sout_valid = (state_q != IDLE);

    // Outputs are pure decodes of flops so downstream samplers see no glitches.
    always_comb begin
        sout = 1'b0;
        if (state_q == SHIFT) begin
            sout = shreg_q[WIDTH-1];
        end
`ifdef PISO_PARITY_EN
        if (state_q == PAR) begin
            sout = par_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = CNT_W'(WIDTH - 1);
`ifdef PISO_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (last_bit) begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    if (accept) begin
                        state_d = SHIFT;
                        shreg_d = din;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    par_d   = ^din;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed self-checking bench for piso_serial_tx at WIDTH=8.
// Compare vector order: {sout, sout_valid, done, busy, din_ready}.
module tb_piso_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    localparam logic [4:0] IDLE_V = 5'b00001;

    piso_serial_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] observed();
        return {sout, sout_valid, done, busy, din_ready};
    endfunction

    // Bit k (1-based) of a frame carrying w; slot 9 is the even-parity bit.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k >= 1 && k <= 8) return w[8-k];
        return ^w;
    endfunction

    task automatic send_word(input logic [7:0] w);
        @(negedge clk);
        din       = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (observed() !== IDLE_V) begin
            errors++;
            $display("FAIL reset_t0 got %b exp %b", observed(), IDLE_V);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (observed() !== IDLE_V) begin
                errors++;
                $display("FAIL reset_low got %b exp %b", observed(), IDLE_V);
            end
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (observed() !== IDLE_V) begin
                errors++;
                $display("FAIL reset_idle got %b exp %b", observed(), IDLE_V);
            end
        end
    endtask

    task automatic test_single();
        logic [4:0] e;
        send_word(8'hA5);
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            if (k <= FL) e = {exp_bit(8'hA5, k), 1'b1, k == FL, 1'b1, k == FL};
            else e = IDLE_V;
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL single k=%0d got %b exp %b", k, observed(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        send_word(8'hA5);
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            @(negedge clk);
            if (k <= FL)
                e = {exp_bit(8'hA5, k), 1'b1, k == FL, 1'b1, k == FL};
            else if (k <= 2 * FL)
                e = {exp_bit(8'h3C, k - FL), 1'b1, k == 2 * FL, 1'b1, k == 2 * FL};
            else
                e = IDLE_V;
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL b2b k=%0d got %b exp %b", k, observed(), e);
            end
            if (k == 2) begin
                din       = 8'h3C;
                din_valid = 1'b1;
            end
            if (k == FL + 1) din_valid = 1'b0;
        end
    endtask

    task automatic test_busy_ignore();
        logic [4:0] e;
        send_word(8'h00);
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            @(negedge clk);
            if (k <= FL)
                e = {1'b0, 1'b1, k == FL, 1'b1, k == FL};
            else if (k <= 2 * FL)
                e = {exp_bit(8'hFF, k - FL), 1'b1, k == 2 * FL, 1'b1, k == 2 * FL};
            else
                e = IDLE_V;
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL busy k=%0d got %b exp %b", k, observed(), e);
            end
            if (k == 2) begin
                din       = 8'hFF;
                din_valid = 1'b1;
            end
            if (k == FL + 1) din_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        send_word(8'hA5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = {exp_bit(8'hA5, k), 1'b1, 1'b0, 1'b1, 1'b0};
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL mid_pre k=%0d got %b exp %b", k, observed(), e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== IDLE_V) begin
            errors++;
            $display("FAIL mid_async got %b exp %b", observed(), IDLE_V);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (FL) begin
            @(negedge clk);
            checks++;
            if (observed() !== IDLE_V) begin
                errors++;
                $display("FAIL mid_nodone got %b exp %b", observed(), IDLE_V);
            end
        end
        send_word(8'h81);
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            if (k <= FL) e = {exp_bit(8'h81, k), 1'b1, k == FL, 1'b1, k == FL};
            else e = IDLE_V;
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL mid_after k=%0d got %b exp %b", k, observed(), e);
            end
        end
    endtask

    task automatic test_parity();
`ifdef PISO_PARITY_EN
        send_word(8'hA5);
        repeat (9) @(negedge clk);
        checks++;
        if ({sout, sout_valid, done} !== 3'b011) begin
            errors++;
            $display("FAIL par_a5 got %b exp %b", {sout, sout_valid, done}, 3'b011);
        end
        @(negedge clk);
        send_word(8'h07);
        repeat (9) @(negedge clk);
        checks++;
        if ({sout, sout_valid, done} !== 3'b111) begin
            errors++;
            $display("FAIL par_07 got %b exp %b", {sout, sout_valid, done}, 3'b111);
        end
        @(negedge clk);
`else
        send_word(8'h07);
        repeat (8) @(negedge clk);
        checks++;
        if ({sout, sout_valid, done} !== 3'b111) begin
            errors++;
            $display("FAIL nopar_last got %b exp %b", {sout, sout_valid, done}, 3'b111);
        end
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_V) begin
            errors++;
            $display("FAIL nopar_end got %b exp %b", observed(), IDLE_V);
        end
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
